scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer.sv | 140 ++++++++++++++
 tb/tb_scan_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// Channel scan sequencer: steps a 2-to-4 decoder select through the enabled mask bits.
// Define SCAN_BLANK_EN to insert one decoder-disabled BLANK cycle on every channel advance.
module scan_sequencer #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] mask,
  output logic [1:0] w,
  output logic       en,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN
`ifdef SCAN_BLANK_EN
    , BLANK
`endif
  } state_t;

  state_t     r_state, w_stateNext;
  logic [1:0] r_chan, w_chanNext;
  logic [7:0] r_dwell, w_dwellNext;
  logic       r_en, r_busy, r_frame;
  logic       w_frameNext;
  logic [1:0] w_firstChan, w_nextChan;
  logic       w_wrap, w_dwellLast;
`ifdef SCAN_BLANK_EN
  logic [1:0] r_pend, w_pendNext;
`endif

  assign w_dwellLast = (r_dwell == 8'(DWELL - 1));
  assign w_wrap      = (w_nextChan <= r_chan);

  // Lowest enabled channel, used when a scan is launched from IDLE.
  always_comb begin
    w_firstChan = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (mask[k]) w_firstChan = 2'(k);
    end
  end

  // Next enabled channel above the current one, wrapping 3->0 and back onto itself.
  always_comb begin
    w_nextChan = r_chan;
    for (int k = 4; k >= 1; k--) begin
      if (mask[r_chan + 2'(k)]) w_nextChan = r_chan + 2'(k);
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_chanNext  = r_chan;
    w_dwellNext = r_dwell;
    w_frameNext = 1'b0;
`ifdef SCAN_BLANK_EN
    w_pendNext  = r_pend;
`endif
    case (r_state)
      IDLE: begin
        w_chanNext  = 2'd0;
        w_dwellNext = 8'd0;
        if (start && !stop && (mask != 4'd0)) begin
          w_stateNext = SCAN;
          w_chanNext  = w_firstChan;
        end
      end
      SCAN: begin
        if (stop || (w_dwellLast && (mask == 4'd0))) begin
          w_stateNext = IDLE;
          w_chanNext  = 2'd0;
          w_dwellNext = 8'd0;
        end else if (w_dwellLast) begin
          w_frameNext = w_wrap;
          w_dwellNext = 8'd0;
`ifdef SCAN_BLANK_EN
          w_stateNext = BLANK;
          w_pendNext  = w_nextChan;
`else
          w_chanNext  = w_nextChan;
`endif
        end else begin
          w_dwellNext = r_dwell + 8'd1;
        end
      end
`ifdef SCAN_BLANK_EN
      BLANK: begin
        w_dwellNext = 8'd0;
        if (stop) begin
          w_stateNext = IDLE;
          w_chanNext  = 2'd0;
        end else begin
          w_stateNext = SCAN;
          w_chanNext  = r_pend;
        end
      end
`endif
      default: begin
        w_stateNext = IDLE;
        w_chanNext  = 2'd0;
        w_dwellNext = 8'd0;
      end
    endcase
  end

  // en/busy are registered from the next state so every output comes straight off a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_chan  <= 2'd0;
      r_dwell <= 8'd0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_frame <= 1'b0;
`ifdef SCAN_BLANK_EN
      r_pend  <= 2'd0;
`endif
    end else begin
      r_state <= w_stateNext;
      r_chan  <= w_chanNext;
      r_dwell <= w_dwellNext;
      r_en    <= (w_stateNext == SCAN);
      r_busy  <= (w_stateNext != IDLE);
      r_frame <= w_frameNext;
`ifdef SCAN_BLANK_EN
      r_pend  <= w_pendNext;
`endif
    end
  end

  assign w          = r_chan;
  assign en         = r_en;
  assign busy       = r_busy;
  assign frame_done = r_frame;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: directed sequences plus randomized traffic
// compared every cycle against a channel-list model of the scan rules.
module tb_scan_sequencer;

  localparam int DWELL = 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] mask;
  logic [1:0] w;
  logic       en;
  logic       busy;
  logic       frame_done;

  int tests = 0;
  int fails = 0;

  scan_sequencer #(.DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mask(mask),
    .w(w), .en(en), .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: which channel is selected, how many cycles it has been held, and whether a gap is in progress.
  bit mActive = 1'b0;
  int mChan   = 0;
  int mAge    = 0;
  bit mGap    = 1'b0;
  int mPend   = 0;
  bit mFrame  = 1'b0;

  function automatic int nextEnabled(input int c, input logic [3:0] m);
    for (int i = c + 1; i < 4; i++) begin
      if (m[i]) return i;
    end
    return -1;
  endfunction

  function automatic int nextOrWrap(input int c, input logic [3:0] m);
    int n;
    n = nextEnabled(c, m);
    return (n < 0) ? nextEnabled(-1, m) : n;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mActive <= 1'b0; mChan <= 0; mAge <= 0; mGap <= 1'b0; mPend <= 0; mFrame <= 1'b0;
    end else if (!mActive) begin
      mFrame <= 1'b0;
      if (start && !stop && mask != 4'd0) begin
        mActive <= 1'b1; mChan <= nextEnabled(-1, mask); mAge <= 0; mGap <= 1'b0;
      end
    end else if (stop) begin
      mActive <= 1'b0; mChan <= 0; mAge <= 0; mGap <= 1'b0; mFrame <= 1'b0;
    end else if (mGap) begin
      mGap <= 1'b0; mChan <= mPend; mAge <= 0; mFrame <= 1'b0;
    end else if (mAge == DWELL - 1) begin
      if (mask == 4'd0) begin
        mActive <= 1'b0; mChan <= 0; mAge <= 0; mFrame <= 1'b0;
      end else begin
        mFrame <= (nextEnabled(mChan, mask) < 0);
`ifdef SCAN_BLANK_EN
        mGap  <= 1'b1;
        mPend <= nextOrWrap(mChan, mask);
        mAge  <= 0;
`else
        mChan <= nextOrWrap(mChan, mask);
        mAge  <= 0;
`endif
      end
    end else begin
      mAge <= mAge + 1; mFrame <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [1:0] eW, input logic eEn,
                             input logic eBusy, input logic eFd);
    tests++;
    if (w !== eW || en !== eEn || busy !== eBusy || frame_done !== eFd) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got w=%0d en=%0b busy=%0b frame_done=%0b, expected w=%0d en=%0b busy=%0b frame_done=%0b",
               name, $time, w, en, busy, frame_done, eW, eEn, eBusy, eFd);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic p, input logic [3:0] m);
    rst = r; start = s; stop = p; mask = m;
  endtask

  // Advance one cycle and compare the DUT with the model away from the rising edge.
  task automatic step();
    @(negedge clk);
    checkOutput("model", mActive ? 2'(mChan) : 2'd0, mActive && !mGap, mActive, mFrame);
  endtask

  task automatic waitForChannel(input string name, input int ch, input int age);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (mActive && !mGap && mChan == ch && mAge == age) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("[TB] FAIL %s: channel %0d age %0d not reached within 40 cycles", name, ch, age);
    end
  endtask

  logic [1:0] seqA[10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
  logic [1:0] seqB[6]  = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1};
  logic       enC[6]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    step();
    checkOutput("reset_idle", 2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0);
    step();

`ifdef SCAN_BLANK_EN
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0001);
    for (int k = 0; k < 6; k++) begin
      step();
      checkOutput("blank_single", 2'd0, enC[k], 1'b1, !enC[k]);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001);
    step();
`else
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111);
    for (int k = 0; k < 10; k++) begin
      step();
      checkOutput("seq_1111", seqA[k], 1'b1, 1'b1, k == 8);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b1111);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1010);
    for (int k = 0; k < 6; k++) begin
      step();
      checkOutput("seq_1010", seqB[k], 1'b1, 1'b1, k == 4);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b1010);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b1010);
    step();
`endif

    // Reset held for two cycles in the middle of a scan.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111);
    step();
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 4'b1111);
    step();
    checkOutput("reset_midscan", 2'd0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("reset_hold", 2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111);
    step();

    // Stop together with start on the second cycle of channel 2.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111);
    waitForChannel("stop_reach", 2, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b1111);
    step();
    checkOutput("stop_abort", 2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111);
    step();
    checkOutput("stop_stays_idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // Mask cleared while channel 1 is selected.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111);
    waitForChannel("maskclr_reach", 1, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    step();
    checkOutput("maskclr_hold", 2'd1, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("maskclr_idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // Start with an empty mask is refused.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000);
    step();
    checkOutput("start_nomask", 2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    step();

    for (int i = 0; i < 3000; i++) begin
      logic [3:0] m;
      m = mask;
      if ($urandom_range(0, 99) < 10) m = 4'($urandom_range(0, 15));
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 5, m);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
